// File: rtl/spi_slave_frame_rx.sv
// SPI slave that receives 32-bit frames (24 data bits + CRC-8) and returns a
// 24-bit response word with its CRC-8 on miso during the same frame.
module spi_slave_frame_rx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sck,
    input  logic        csn,
    input  logic        mosi,
    output logic        miso,
    input  logic [23:0] tx_data,
    input  logic        tx_load,
    output logic [23:0] rx_data,
    output logic [7:0]  rx_crc,
    output logic        rx_crc_err,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] crc8_24(input logic [23:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 23; i >= 0; i--) begin
            c = crc8_bit(c, d[i]);
        end
        return c;
    endfunction

    logic        r_sck_s1, r_sck_s2, r_sck_d;
    logic        r_csn_s1, r_csn_s2, r_csn_d;
    logic        r_mosi_s1, r_mosi_s2;
    logic        r_flush, r_armed;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_tx_sr, r_rx_sr;
    logic [23:0] r_tx_buf, r_rx_data;
    logic [7:0]  r_rx_crc, r_crc_calc;
    logic [5:0]  r_bit_cnt;
    logic        r_miso, r_rx_crc_err, r_rx_valid, r_frame_err, r_overrun;

    logic w_sck_rise, w_sck_fall, w_csn_fall, w_csn_rise, w_accept;
    logic w_start, w_deliver, w_ovr, w_ferr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_csn_s1  <= 1'b1;
            r_csn_s2  <= 1'b1;
            r_csn_d   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_flush   <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_sck_s1  <= sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_csn_s1  <= csn;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_flush   <= 1'b1;
            // Only arm after csn is genuinely seen high, so a frame cut by reset is not resumed.
            if (r_flush && r_csn_s1)
                r_armed <= 1'b1;
        end
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s2 & r_sck_d;
    assign w_csn_fall = r_armed & ~r_csn_s2 & r_csn_d;
    assign w_csn_rise = r_csn_s2 & ~r_csn_d;
    assign w_accept   = r_rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_deliver   = 1'b0;
        w_ovr       = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt = SHIFT;
                    w_start     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_csn_rise)
                    w_state_nxt = CHECK;
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (r_bit_cnt == 6'd32) begin
                    if (!r_rx_valid || w_accept)
                        w_deliver = 1'b1;
                    else
                        w_ovr = 1'b1;
                end else begin
                    w_ferr = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_buf     <= 24'h0;
            r_tx_sr      <= 32'h0;
            r_rx_sr      <= 32'h0;
            r_crc_calc   <= 8'hFF;
            r_bit_cnt    <= 6'd0;
            r_miso       <= 1'b0;
            r_rx_data    <= 24'h0;
            r_rx_crc     <= 8'h0;
            r_rx_crc_err <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (tx_load)
                r_tx_buf <= tx_data;

            if (w_start) begin
                r_tx_sr    <= {r_tx_buf, crc8_24(r_tx_buf)};
                r_bit_cnt  <= 6'd0;
                r_crc_calc <= 8'hFF;
            end else if (r_state == SHIFT) begin
                if (w_sck_rise)
                    r_tx_sr <= {r_tx_sr[30:0], 1'b0};
                if (w_sck_fall && (r_bit_cnt < 6'd32)) begin
                    r_rx_sr   <= {r_rx_sr[30:0], r_mosi_s2};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (r_bit_cnt < 6'd24)
                        r_crc_calc <= crc8_bit(r_crc_calc, r_mosi_s2);
                end
            end

            // Using the next state keeps miso low for the whole CHECK cycle.
            if (w_state_nxt != SHIFT)
                r_miso <= 1'b0;
            else if ((r_state == SHIFT) && w_sck_rise)
                r_miso <= r_tx_sr[31];

            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;

            if (w_deliver) begin
                r_rx_data    <= r_rx_sr[31:8];
                r_rx_crc     <= r_rx_sr[7:0];
                r_rx_crc_err <= (r_crc_calc != r_rx_sr[7:0]);
                r_rx_valid   <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign miso       = r_miso;
    assign rx_data    = r_rx_data;
    assign rx_crc     = r_rx_crc;
    assign rx_crc_err = r_rx_crc_err;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx: frame reception, CRC, response word,
// overrun, aborted frames and mid-frame reset.
module tb_spi_slave_frame_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sck, csn, mosi, miso;
    logic [23:0] tx_data;
    logic        tx_load;
    logic [23:0] rx_data;
    logic [7:0]  rx_crc;
    logic        rx_crc_err, rx_valid, rx_ready, frame_err, overrun;

    int total = 0;
    int bad   = 0;

    int          fe_cnt = 0, ov_cnt = 0, vld_cnt = 0;
    logic [23:0] cap_data = 24'h0;
    logic [7:0]  cap_crc = 8'h0;
    logic        cap_err = 1'b0;

    spi_slave_frame_rx dut (
        .clk(clk), .rstn(rstn), .sck(sck), .csn(csn), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_crc(rx_crc),
        .rx_crc_err(rx_crc_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (rx_valid) begin
            vld_cnt++;
            cap_data = rx_data;
            cap_crc  = rx_crc;
            cap_err  = rx_crc_err;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // sck period is 10 clk; master changes mosi on sck rise, samples miso just before the fall.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit release_cs,
                              input int load_at, input logic [23:0] load_val,
                              output logic [31:0] got);
        got = 32'h0;
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[31-i];
            sck  = 1'b1;
            if (i == load_at) begin
                tx_data = load_val;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            got[31-i] = miso;
            sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        if (release_cs) csn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
        tx_data = 24'h0; tx_load = 1'b0; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (miso !== 1'b0)       begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_crc_err !== 1'b0) begin bad++; $display("FAIL reset_rx_crc_err got=%b exp=0", rx_crc_err); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (rx_data !== 24'h0)   begin bad++; $display("FAIL reset_rx_data got=%h exp=000000", rx_data); end
        total++; if (rx_crc !== 8'h0)     begin bad++; $display("FAIL reset_rx_crc got=%h exp=00", rx_crc); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] got;
        int fe0, ov0, v0, lat;
        tx_data = 24'hABCDEF; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0; tx_data = 24'h0;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cnt;
        send_frame(32'hABCDEF6F, 32, 1'b1, -1, 24'h0, got);
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (rx_valid) begin lat = k; break; end
        end
        total++; if (lat == 0) begin bad++; $display("FAIL basic_latency got=no rx_valid within 4 clk exp=<=4"); end
        total++; if (rx_data !== 24'hABCDEF) begin bad++; $display("FAIL basic_rx_data got=%h exp=abcdef", rx_data); end
        total++; if (rx_crc !== 8'h6F)       begin bad++; $display("FAIL basic_rx_crc got=%h exp=6f", rx_crc); end
        total++; if (rx_crc_err !== 1'b0)    begin bad++; $display("FAIL basic_crc_err got=%b exp=0", rx_crc_err); end
        repeat (8) @(negedge clk);
        total++; if (vld_cnt - v0 != 1)   begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", vld_cnt - v0); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL basic_valid_clear got=%b exp=0", rx_valid); end
        total++; if (got !== 32'hABCDEF6F) begin bad++; $display("FAIL basic_miso_word got=%h exp=abcdef6f", got); end
        total++; if (miso !== 1'b0)       begin bad++; $display("FAIL basic_miso_idle got=%b exp=0", miso); end
        total++; if ((fe_cnt - fe0) + (ov_cnt - ov0) != 0) begin bad++; $display("FAIL basic_no_errors got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
    endtask

    task automatic test_tx_midload;
        logic [31:0] got;
        send_frame(32'h0000000E, 32, 1'b1, 10, 24'h000000, got);
        repeat (10) @(negedge clk);
        total++; if (got !== 32'hABCDEF6F) begin bad++; $display("FAIL midload_cur_frame got=%h exp=abcdef6f", got); end
        total++; if (rx_data !== 24'h0 || rx_crc !== 8'h0E || rx_crc_err !== 1'b0)
            begin bad++; $display("FAIL midload_rx got=%h/%h/%b exp=000000/0e/0", rx_data, rx_crc, rx_crc_err); end
        send_frame(32'hABCDEF6F, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (got !== 32'h0000000E) begin bad++; $display("FAIL midload_next_frame got=%h exp=0000000e", got); end
    endtask

    task automatic test_crc_err;
        logic [31:0] got;
        int v0;
        v0 = vld_cnt;
        send_frame(32'hABCDEF6E, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (vld_cnt - v0 != 1) begin bad++; $display("FAIL crcerr_delivered got=%0d exp=1", vld_cnt - v0); end
        total++; if (cap_err !== 1'b1)  begin bad++; $display("FAIL crcerr_flag got=%b exp=1", cap_err); end
        total++; if (cap_crc !== 8'h6E) begin bad++; $display("FAIL crcerr_rx_crc got=%h exp=6e", cap_crc); end
        total++; if (cap_data !== 24'hABCDEF) begin bad++; $display("FAIL crcerr_rx_data got=%h exp=abcdef", cap_data); end
    endtask

    task automatic test_overrun;
        logic [31:0] got;
        int ov0;
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(32'hABCDEF6F, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (rx_valid !== 1'b1 || rx_data !== 24'hABCDEF)
            begin bad++; $display("FAIL overrun_first_held got=%b/%h exp=1/abcdef", rx_valid, rx_data); end
        send_frame(32'h0000000E, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (ov_cnt - ov0 != 1) begin bad++; $display("FAIL overrun_pulse got=%0d exp=1", ov_cnt - ov0); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 24'hABCDEF || rx_crc !== 8'h6F || rx_crc_err !== 1'b0)
            begin bad++; $display("FAIL overrun_kept got=%b/%h/%h/%b exp=1/abcdef/6f/0", rx_valid, rx_data, rx_crc, rx_crc_err); end
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL overrun_accept got=%b exp=0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        int ov0;
        rx_ready = 1'b0;
        send_frame(32'h0000000E, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        ov0 = ov_cnt;
        send_frame(32'hABCDEF6F, 32, 1'b1, -1, 24'h0, got);
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (rx_valid !== 1'b1 || rx_data !== 24'hABCDEF || rx_crc !== 8'h6F)
            begin bad++; $display("FAIL b2b_new_frame got=%b/%h/%h exp=1/abcdef/6f", rx_valid, rx_data, rx_crc); end
        total++; if (ov_cnt - ov0 != 0) begin bad++; $display("FAIL b2b_no_overrun got=%0d exp=0", ov_cnt - ov0); end
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", rx_valid); end
    endtask

    task automatic test_frame_err;
        logic [31:0] got;
        int fe0, v0;
        fe0 = fe_cnt; v0 = vld_cnt;
        send_frame(32'h12345678, 20, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - fe0); end
        total++; if (vld_cnt - v0 != 0) begin bad++; $display("FAIL ferr_no_valid got=%0d exp=0", vld_cnt - v0); end
        total++; if (rx_data !== 24'hABCDEF) begin bad++; $display("FAIL ferr_rx_kept got=%h exp=abcdef", rx_data); end
        send_frame(32'h0000000E, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (vld_cnt - v0 != 1 || cap_data !== 24'h0 || cap_crc !== 8'h0E || cap_err !== 1'b0)
            begin bad++; $display("FAIL ferr_recover got=%0d/%h/%h/%b exp=1/000000/0e/0", vld_cnt - v0, cap_data, cap_crc, cap_err); end
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL ferr_single got=%0d exp=1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] got;
        int fe0, ov0, v0;
        send_frame(32'hABCDEF6F, 10, 1'b0, -1, 24'h0, got);
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cnt;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rx_crc !== 8'h0 || rx_data !== 24'h0) begin bad++; $display("FAIL midrst_rx got=%h/%h exp=000000/00", rx_data, rx_crc); end
        total++; if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_crc_err !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            begin bad++; $display("FAIL midrst_flags got=%b%b%b%b%b exp=00000", miso, rx_valid, rx_crc_err, frame_err, overrun); end
        rstn = 1'b1;
        sck = 1'b0;
        repeat (5) @(negedge clk);
        csn = 1'b1;
        repeat (10) @(negedge clk);
        total++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (vld_cnt - v0) != 0)
            begin bad++; $display("FAIL midrst_no_pulses got=%0d exp=0", (fe_cnt - fe0) + (ov_cnt - ov0) + (vld_cnt - v0)); end
        send_frame(32'hABCDEF6F, 32, 1'b1, -1, 24'h0, got);
        repeat (10) @(negedge clk);
        total++; if (vld_cnt - v0 != 1 || cap_data !== 24'hABCDEF || cap_err !== 1'b0)
            begin bad++; $display("FAIL midrst_next_frame got=%0d/%h/%b exp=1/abcdef/0", vld_cnt - v0, cap_data, cap_err); end
        total++; if (got !== 32'h0000000E) begin bad++; $display("FAIL midrst_tx_buf got=%h exp=0000000e", got); end
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL midrst_no_ferr got=%0d exp=0", fe_cnt - fe0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_tx_midload;
        test_crc_err;
        test_overrun;
        test_back_to_back;
        test_frame_err;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_frame_rx.md
SPI_SLAVE_FRAME_RX -- requirements
Module: spi_slave_frame_rx

Interface
REQ-001 SHALL have no parameters; frame length is fixed at 32 bits: 24 data bits MSB-first, then 8 CRC bits MSB-first.
REQ-002 clk  input  1  system clock; SHALL be at least 8x the sck frequency.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 sck  input  1  SPI clock from master, idle low, asynchronous to clk.
REQ-005 csn  input  1  SPI chip select from master, active low, asynchronous to clk.
REQ-006 mosi  input  1  serial data from master.
REQ-007 miso  output  1  serial data to master.
REQ-008 tx_data  input  24  response word for the next frame.
REQ-009 tx_load  input  1  one-clk strobe that writes tx_data into the response buffer.
REQ-010 rx_data  output  24  received data word.
REQ-011 rx_crc  output  8  received CRC byte.
REQ-012 rx_crc_err  output  1  high with rx_valid when the received CRC differs from the computed CRC.
REQ-013 rx_valid  output  1  received frame available.
REQ-014 rx_ready  input  1  consumer accepts the frame.
REQ-015 frame_err  output  1  one-clk pulse: frame aborted with a bit count other than 32.
REQ-016 overrun  output  1  one-clk pulse: frame completed while rx_valid was still pending.

Function
REQ-017 sck, csn and mosi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized sck.
REQ-018 csn_s (synchronized csn) SHALL define frame boundaries: falling edge = start, rising edge = end.
REQ-019 FSM SHALL have states IDLE, SHIFT, CHECK.
- IDLE -> SHIFT on csn_s falling edge.
- SHIFT -> CHECK on csn_s rising edge.
- CHECK -> IDLE after one clk.
REQ-020 On entry to SHIFT, the block SHALL copy tx_buf plus its CRC-8 into a 32-bit tx shift register, clear bit_cnt (6-bit) and preset the rx CRC to 0xFF.
REQ-021 On each sck rise in SHIFT, the block SHALL drive miso with the next tx bit, MSB first; the first rise SHALL drive bit 31.
REQ-022 On each sck fall in SHIFT with bit_cnt<32, the block SHALL shift mosi into the rx register and increment bit_cnt.
- Sck falls after bit 32 SHALL be ignored; bit_cnt SHALL saturate at 32.
REQ-023 CRC-8 SHALL use polynomial 0x1D, init 0xFF, no reflection and no final XOR.
- Per bit: fb = crc[7]^bit; crc = (crc<<1) ^ (fb ? 0x1D : 0).
- Applied serially to received data bits 1-24 only.
- The tx CRC SHALL use the same function over tx_buf.
REQ-024 In CHECK with bit_cnt==32 and rx_valid low, the block SHALL:
- load rx_data and rx_crc;
- set rx_crc_err = (computed != received);
- assert rx_valid.
A frame with a CRC error SHALL still be delivered.
REQ-025 In CHECK with bit_cnt==32 and rx_valid high, the block SHALL pulse overrun, drop the new frame, and leave the held outputs unchanged.
REQ-026 In CHECK with bit_cnt!=32, the block SHALL pulse frame_err and leave the rx outputs unchanged.
REQ-027 rx_valid SHALL stay high, and rx_data/rx_crc/rx_crc_err SHALL stay stable, until a clk with rx_valid&rx_ready; rx_valid SHALL clear on the following edge.
REQ-028 If acceptance (rx_valid&rx_ready) and a new delivery occur in the same CHECK clk, the new frame SHALL be delivered and rx_valid SHALL remain high; no overrun SHALL be flagged.
REQ-029 tx_load SHALL update tx_buf in any state; a load during SHIFT SHALL affect only the next frame.
REQ-030 miso SHALL be 0 while in IDLE or CHECK.
REQ-031 Latency: rx_valid SHALL rise no more than 4 clk after the csn pin rises.

Reset
REQ-032 On rstn low, the block SHALL:
- set state=IDLE;
- set miso, rx_valid, rx_crc_err, frame_err and overrun to 0;
- set rx_data=0x000000, rx_crc=0x00, tx_buf=0x000000, bit_cnt=0;
- clear the synchronizers to csn=1, sck=0, mosi=0.
REQ-033 A reset asserted mid-frame SHALL abort the frame with no rx_valid, overrun or frame_err pulse; the block SHALL restart cleanly on the next csn fall after rstn releases.

Verification
REQ-034 Master sends 0xABCDEF + 0x6F with rx_ready=1 -> rx_data=0xABCDEF, rx_crc=0x6F, rx_crc_err=0, rx_valid high for 1 clk.
REQ-035 tx_load with 0xABCDEF, then a frame -> miso bits on the 32 sck rises = 0xABCDEF6F.
REQ-036 Master sends 0xABCDEF + 0x6E -> rx_valid=1 with rx_crc_err=1 and rx_crc=0x6E.
REQ-037 Two good frames with rx_ready=0 -> first frame held, overrun pulses once, rx_data still shows the first word.
REQ-038 csn released after 20 sck cycles -> frame_err pulse, rx_valid stays 0; the next full frame is received correctly.
REQ-039 rstn pulsed low after 10 bits -> all outputs at reset values, no error pulses; a following frame passes.
